// File: rtl/parity_stream.sv
// parity_stream: packet-wide parity over a valid/ready beat stream, one registered result per packet.
// Define PARITY_STREAM_CHECK_EN to compare the received in_par against the generated check bit.
module parity_stream #(
  parameter int DATA_W    = 32,
  parameter int MAX_BEATS = 16,
  localparam int CNT_W    = $clog2(MAX_BEATS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sel,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic             in_last,
  input  logic             in_par,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_check,
  output logic             out_err,
  output logic             out_ovf,
  output logic [CNT_W-1:0] out_beats
);
  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;
  state_t           state_q;
  logic             acc_q, sel_q, check_q, ovf_q;
  logic [CNT_W-1:0] cnt_q, beats_q;
  logic             fire, first, acc_d, sel_d, full, close, ovf_d, check_d;
  logic [CNT_W-1:0] cnt_d;
  assign in_ready  = state_q != HOLD;
  assign out_valid = state_q == HOLD;
  assign fire      = in_valid && in_ready;
  assign first     = state_q == IDLE;
  // sel is taken only from the first beat so mid-packet changes cannot flip the result
  assign sel_d     = first ? sel : sel_q;
  assign acc_d     = (first ? 1'b0 : acc_q) ^ (^in_data);
  assign cnt_d     = first ? CNT_W'(1) : cnt_q + 1'b1;
  assign full      = cnt_d == CNT_W'(MAX_BEATS);
  assign close     = in_last || full;
  assign ovf_d     = full && !in_last;
  assign check_d   = acc_d ^ sel_d;
  assign out_check = check_q;
  assign out_ovf   = ovf_q;
  assign out_beats = beats_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= 1'b0;
      sel_q   <= 1'b0;
      cnt_q   <= '0;
      check_q <= 1'b0;
      ovf_q   <= 1'b0;
      beats_q <= '0;
    end else if (state_q == HOLD) begin
      if (out_ready) state_q <= IDLE;
    end else if (fire) begin
      acc_q   <= acc_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      state_q <= close ? HOLD : ACCUM;
      if (close) begin
        check_q <= check_d;
        ovf_q   <= ovf_d;
        beats_q <= cnt_d;
      end
    end
  end
`ifdef PARITY_STREAM_CHECK_EN
  logic err_q;
  assign out_err = err_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else if (fire && close) err_q <= !ovf_d && (in_par != check_d);
  end
`else
  logic unused_par;
  assign unused_par = in_par;
  assign out_err    = 1'b0;
`endif
endmodule
